// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: decode-stage branch resolution bus (inputs from decode, results back)
interface branch_resolve_unit_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
  logic in_valid;
  logic stall;
  logic flush;
  logic is_branch;
  logic [XLEN-1:0] pc;
  logic [2:0] funct3;
  logic pred_taken_d;
  logic [1:0] fub_cs_1;
  logic [1:0] fub_cs_2;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] mem_out;
  logic [XLEN-1:0] wb_out;
  logic [XLEN-1:0] fetch_pc;
  logic pred_taken;
  logic res_valid;
  logic res_taken;
  logic res_illegal;
  logic mispredict;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mispred_count;
  modport master (
    output in_valid, stall, flush, is_branch, pc, funct3, pred_taken_d, fub_cs_1, fub_cs_2,
           rs1, rs2, alu_out, mem_out, wb_out, fetch_pc,
    input pred_taken, res_valid, res_taken, res_illegal, mispredict, br_count, mispred_count
  );
  modport slave (
    input in_valid, stall, flush, is_branch, pc, funct3, pred_taken_d, fub_cs_1, fub_cs_2,
          rs1, rs2, alu_out, mem_out, wb_out, fetch_pc,
    output pred_taken, res_valid, res_taken, res_illegal, mispredict, br_count, mispred_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: forwarded-operand branch evaluation, registered outcome, 2-bit BHT and statistics
module branch_resolve_unit #(
  parameter int XLEN = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  branch_resolve_unit_if.slave b
);
  logic [1:0] bht [2**BHT_IDX_W];
  logic [XLEN-1:0] op1, op2;
  logic eq, lt, ltu, cond, illegal, taken, accept, legal_acc, mis;
  logic [BHT_IDX_W-1:0] idx, fidx;
  logic unused;
  assign unused = ^{b.pc[XLEN-1:BHT_IDX_W+2], b.pc[1:0], b.fetch_pc[XLEN-1:BHT_IDX_W+2], b.fetch_pc[1:0]};
  assign idx = b.pc[BHT_IDX_W+1:2];
  assign fidx = b.fetch_pc[BHT_IDX_W+1:2];
  assign b.pred_taken = bht[fidx][1];
  // operand forwarding, condition evaluation and slot qualification
  always_comb begin
    op1 = b.fub_cs_1 == 2'b00 ? b.rs1 : b.fub_cs_1 == 2'b10 ? b.alu_out : b.fub_cs_1 == 2'b01 ? b.mem_out : b.wb_out;
    op2 = b.fub_cs_2 == 2'b00 ? b.rs2 : b.fub_cs_2 == 2'b10 ? b.alu_out : b.fub_cs_2 == 2'b01 ? b.mem_out : b.wb_out;
    eq = op1 == op2;
    lt = $signed(op1) < $signed(op2);
    ltu = op1 < op2;
    illegal = b.funct3[2:1] == 2'b01;
    cond = b.funct3[2] ? (b.funct3[1] ? ltu : lt) : eq;
    taken = !illegal && (cond ^ b.funct3[0]);
    accept = b.in_valid && b.is_branch && !b.stall && !b.flush;
    legal_acc = accept && !illegal;
    mis = legal_acc && (taken != b.pred_taken_d);
  end
  // registered outcome and saturating statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b.res_valid <= 1'b0;
      b.res_taken <= 1'b0;
      b.res_illegal <= 1'b0;
      b.mispredict <= 1'b0;
      b.br_count <= '0;
      b.mispred_count <= '0;
    end else if (b.flush) begin
      b.res_valid <= 1'b0;
      b.res_taken <= 1'b0;
      b.res_illegal <= 1'b0;
      b.mispredict <= 1'b0;
    end else if (!b.stall) begin
      b.res_valid <= accept;
      b.res_taken <= accept && taken;
      b.res_illegal <= accept && illegal;
      b.mispredict <= mis;
      if (legal_acc && b.br_count != {CNT_W{1'b1}}) b.br_count <= b.br_count + 1'b1;
      if (mis && b.mispred_count != {CNT_W{1'b1}}) b.mispred_count <= b.mispred_count + 1'b1;
    end
  end
  // BHT training on legal accepted branches; reset restores weakly not-taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= 2'b01;
    end else if (legal_acc) begin
      bht[idx] <= taken ? (bht[idx] == 2'b11 ? 2'b11 : bht[idx] + 2'b01) : (bht[idx] == 2'b00 ? 2'b00 : bht[idx] - 2'b01);
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed + randomized checks against a behavioural model
module tb_branch_resolve_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  branch_resolve_unit_if bi ();
  branch_resolve_unit dut (.clk(clk), .rst(rst), .b(bi));
  always #5 clk = ~clk;

  int m_bht [64];
  int m_br, m_mis;
  logic m_valid, m_taken, m_ill, m_mp;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] fsel(input logic [1:0] cs, input logic [31:0] r);
    case (cs)
      2'b00: return r;
      2'b10: return bi.alu_out;
      2'b01: return bi.mem_out;
      default: return bi.wb_out;
    endcase
  endfunction

  // returns {illegal, taken}
  function automatic logic [1:0] evalb(input logic [2:0] f, input logic [31:0] a, input logic [31:0] c);
    case (f)
      3'd0: return {1'b0, a == c};
      3'd1: return {1'b0, a != c};
      3'd4: return {1'b0, $signed(a) < $signed(c)};
      3'd5: return {1'b0, $signed(a) >= $signed(c)};
      3'd6: return {1'b0, a < c};
      3'd7: return {1'b0, a >= c};
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] cur_eval();
    return evalb(bi.funct3, fsel(bi.fub_cs_1, bi.rs1), fsel(bi.fub_cs_2, bi.rs2));
  endfunction

  // behavioural model of the resolution stage
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 0; m_taken <= 0; m_ill <= 0; m_mp <= 0; m_br <= 0; m_mis <= 0;
      foreach (m_bht[i]) m_bht[i] <= 1;
    end else if (bi.flush) begin
      m_valid <= 0; m_taken <= 0; m_ill <= 0; m_mp <= 0;
    end else if (!bi.stall) begin
      m_valid <= bi.in_valid && bi.is_branch;
      m_taken <= bi.in_valid && bi.is_branch && cur_eval() == 2'b01;
      m_ill <= bi.in_valid && bi.is_branch && cur_eval() == 2'b10;
      m_mp <= bi.in_valid && bi.is_branch && !cur_eval()[1] && (cur_eval()[0] != bi.pred_taken_d);
      if (bi.in_valid && bi.is_branch && !cur_eval()[1]) begin
        m_br <= m_br < 65535 ? m_br + 1 : m_br;
        m_bht[(bi.pc / 4) % 64] <= cur_eval()[0] ? (m_bht[(bi.pc / 4) % 64] < 3 ? m_bht[(bi.pc / 4) % 64] + 1 : 3)
                                                 : (m_bht[(bi.pc / 4) % 64] > 0 ? m_bht[(bi.pc / 4) % 64] - 1 : 0);
        if (cur_eval()[0] != bi.pred_taken_d) m_mis <= m_mis < 65535 ? m_mis + 1 : m_mis;
      end
    end
  end

  // compare process: every output, every cycle
  always @(negedge clk) begin
    chk("pred_taken", bi.pred_taken, m_bht[(bi.fetch_pc / 4) % 64] >= 2);
    chk("res_valid", bi.res_valid, m_valid);
    chk("res_taken", bi.res_taken, m_taken);
    chk("res_illegal", bi.res_illegal, m_ill);
    chk("mispredict", bi.mispredict, m_mp);
    chk("br_count", bi.br_count, m_br);
    chk("mispred_count", bi.mispred_count, m_mis);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] c, input logic pd, input logic [31:0] p);
    bi.in_valid = 1; bi.is_branch = 1; bi.funct3 = f; bi.rs1 = a; bi.rs2 = c;
    bi.pred_taken_d = pd; bi.pc = p; bi.fub_cs_1 = 0; bi.fub_cs_2 = 0;
  endtask

  initial begin
    bi.in_valid = 0; bi.stall = 0; bi.flush = 0; bi.is_branch = 0; bi.pc = 0; bi.funct3 = 0;
    bi.pred_taken_d = 0; bi.fub_cs_1 = 0; bi.fub_cs_2 = 0; bi.rs1 = 0; bi.rs2 = 0;
    bi.alu_out = 0; bi.mem_out = 0; bi.wb_out = 0; bi.fetch_pc = 32'h40;
    cyc(); cyc();
    rst = 0;
    cyc();
    chk("rst pred_taken", bi.pred_taken, 0);
    chk("rst res_valid", bi.res_valid, 0);
    chk("rst br_count", bi.br_count, 0);
    br(3'd4, 32'hFFFFFFFF, 1, 1, 32'h100);
    cyc();
    chk("blt res_taken", bi.res_taken, 1);
    br(3'd6, 32'hFFFFFFFF, 1, 0, 32'h100);
    cyc();
    chk("bltu res_taken", bi.res_taken, 0);
    br(3'd0, 0, 5, 0, 32'h104);
    bi.fub_cs_1 = 2'b10; bi.alu_out = 5;
    cyc();
    chk("fwd res_taken", bi.res_taken, 1);
    chk("fwd mispredict", bi.mispredict, 1);
    chk("fwd mispred_count", bi.mispred_count, 1);
    chk("bht16 init", m_bht[16], 1);
    br(3'd0, 0, 0, 1, 32'h40);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bht16 train", m_bht[16], i == 0 ? 2 : 3);
    end
    chk("bht16 pred", bi.pred_taken, 1);
    br(3'd1, 0, 0, 1, 32'h40);
    cyc();
    chk("bht16 dec", m_bht[16], 2);
    chk("bht16 pred2", bi.pred_taken, 1);
    br(3'd0, 0, 1, 1, 32'h40);
    bi.stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall res_valid", bi.res_valid, 1);
      chk("stall br_count", bi.br_count, 8);
      chk("stall pred", bi.pred_taken, 1);
    end
    bi.stall = 0; bi.flush = 1;
    cyc();
    chk("flush res_valid", bi.res_valid, 0);
    chk("flush br_count", bi.br_count, 8);
    chk("flush pred", bi.pred_taken, 1);
    bi.flush = 0;
    br(3'd2, 0, 0, 0, 32'h40);
    cyc();
    chk("ill res_valid", bi.res_valid, 1);
    chk("ill res_illegal", bi.res_illegal, 1);
    chk("ill res_taken", bi.res_taken, 0);
    chk("ill br_count", bi.br_count, 8);
    br(3'd0, 0, 0, 1, 32'h40);
    #1 rst = 1;
    #1;
    chk("arst res_valid", bi.res_valid, 0);
    chk("arst br_count", bi.br_count, 0);
    chk("arst mispred_count", bi.mispred_count, 0);
    chk("arst pred", bi.pred_taken, 0);
    cyc();
    rst = 0;
    for (int n = 0; n < 3000; n++) begin
      bi.in_valid = $urandom_range(0, 9) != 0;
      bi.is_branch = $urandom_range(0, 7) != 0;
      bi.stall = $urandom_range(0, 9) == 0;
      bi.flush = $urandom_range(0, 14) == 0;
      bi.funct3 = 3'($urandom_range(0, 7));
      bi.pred_taken_d = 1'($urandom_range(0, 1));
      bi.fub_cs_1 = 2'($urandom_range(0, 3));
      bi.fub_cs_2 = 2'($urandom_range(0, 3));
      bi.rs1 = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 2)) - 1;
      bi.rs2 = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 2)) - 1;
      bi.alu_out = 32'($urandom_range(0, 2)) - 1;
      bi.mem_out = $urandom;
      bi.wb_out = 32'($urandom_range(0, 2));
      bi.pc = 32'($urandom_range(0, 7)) << 2;
      bi.fetch_pc = 32'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 599) == 0) begin
        #3 rst = 1;
        #2 rst = 0;
      end
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
